// File: rtl/fft_bin_streamer.sv
// fft_bin_streamer
//
// Captures one 16-bin FFT frame into a local buffer on an fft_valid pulse. It
// then streams the bins out one per beat. Each beat carries its magnitude-squared.
// A peak-bin report follows every completed frame.
//
// Ports:
//   clk                 system clock, rising edge
//   rst                 asynchronous, active-low reset
//   fft_valid           one-cycle pulse, fft_d0..fft_d15 valid in that cycle
//   fft_d0..fft_d15     bin words: [31:16] signed real, [15:0] signed imaginary
//   out_valid/out_ready beat handshake (see below)
//   out_bin             bin index of the presented beat
//   out_re, out_im      signed real / imaginary part of the presented bin
//   out_mag             unsigned re*re + im*im
//   out_last            high on the final (bin 15) beat
//   busy                high whenever the FSM is not IDLE
//   peak_valid          one-cycle pulse after the final beat is accepted
//   peak_bin            bin with the largest magnitude in the last completed frame
//   drop_cnt            frames refused while a frame was in flight (saturating)
//   state_dbg           current FSM state (IDLE=0, LOAD=1, SEND=2)
//
// Handshake: a beat transfers on a rising edge where out_valid && out_ready.
// While out_valid is high and out_ready is low, every out_* signal holds.
// out_valid only falls after the final beat has transferred.

module fft_bin_streamer #(
    parameter int NBINS = 16,
    parameter int CNTW  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fft_valid,
    input  logic [31:0]     fft_d0,
    input  logic [31:0]     fft_d1,
    input  logic [31:0]     fft_d2,
    input  logic [31:0]     fft_d3,
    input  logic [31:0]     fft_d4,
    input  logic [31:0]     fft_d5,
    input  logic [31:0]     fft_d6,
    input  logic [31:0]     fft_d7,
    input  logic [31:0]     fft_d8,
    input  logic [31:0]     fft_d9,
    input  logic [31:0]     fft_d10,
    input  logic [31:0]     fft_d11,
    input  logic [31:0]     fft_d12,
    input  logic [31:0]     fft_d13,
    input  logic [31:0]     fft_d14,
    input  logic [31:0]     fft_d15,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_bin,
    output logic [15:0]     out_re,
    output logic [15:0]     out_im,
    output logic [31:0]     out_mag,
    output logic            out_last,
    output logic            busy,
    output logic            peak_valid,
    output logic [3:0]      peak_bin,
    output logic [CNTW-1:0] drop_cnt,
    output logic [1:0]      state_dbg
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] SEND = 2'd2;

    localparam logic [3:0] LAST_BIN = 4'(NBINS - 1);

    logic [1:0]  state;
    logic [31:0] frame_buf [NBINS];
    logic [31:0] fft_in    [NBINS];
    logic [3:0]  idx;
    logic [31:0] peak_mag;
    logic [3:0]  peak_idx;

    logic        handshake;
    logic        final_beat;
    logic        capture;
    logic        drop;

    // Bin that the output registers take at the next edge: bin 0 in LOAD,
    // otherwise the successor of the beat being accepted.
    logic [3:0]         ld_idx;
    logic [31:0]        ld_word;
    logic signed [31:0] ld_re;
    logic signed [31:0] ld_im;
    logic signed [31:0] re_sq;
    logic signed [31:0] im_sq;
    logic [31:0]        ld_mag;

    always_comb begin
        fft_in[0]  = fft_d0;
        fft_in[1]  = fft_d1;
        fft_in[2]  = fft_d2;
        fft_in[3]  = fft_d3;
        fft_in[4]  = fft_d4;
        fft_in[5]  = fft_d5;
        fft_in[6]  = fft_d6;
        fft_in[7]  = fft_d7;
        fft_in[8]  = fft_d8;
        fft_in[9]  = fft_d9;
        fft_in[10] = fft_d10;
        fft_in[11] = fft_d11;
        fft_in[12] = fft_d12;
        fft_in[13] = fft_d13;
        fft_in[14] = fft_d14;
        fft_in[15] = fft_d15;
    end

    assign handshake  = out_valid && out_ready;
    assign final_beat = (state == SEND) && handshake && (idx == LAST_BIN);
    // A new frame is taken when idle or exactly as the last beat leaves.
    // Anything else that arrives mid-frame is refused.
    assign capture    = fft_valid && ((state == IDLE) || final_beat);
    assign drop       = fft_valid && !capture;

    always_comb begin
        ld_idx  = (state == LOAD) ? 4'd0 : idx + 4'd1;
        ld_word = frame_buf[ld_idx];
        // Square in 32 bits.
        // (-32768)^2 = 2^30, so each square fits.
        // The unsigned sum peaks at exactly 2^31.
        ld_re   = 32'(signed'(ld_word[31:16]));
        ld_im   = 32'(signed'(ld_word[15:0]));
        re_sq   = ld_re * ld_re;
        im_sq   = ld_im * ld_im;
        ld_mag  = $unsigned(re_sq) + $unsigned(im_sq);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= '0;
            out_valid  <= 1'b0;
            out_re     <= '0;
            out_im     <= '0;
            out_mag    <= '0;
            out_last   <= 1'b0;
            peak_valid <= 1'b0;
            peak_bin   <= '0;
            peak_mag   <= '0;
            peak_idx   <= '0;
            drop_cnt   <= '0;
            for (int i = 0; i < NBINS; i++) frame_buf[i] <= '0;
        end else begin
            peak_valid <= 1'b0;

            if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNTW'(1);

            if (capture) begin
                for (int i = 0; i < NBINS; i++) frame_buf[i] <= fft_in[i];
            end

            case (state)
                IDLE: begin
                    if (capture) begin
                        idx   <= '0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    out_valid <= 1'b1;
                    out_re    <= ld_word[31:16];
                    out_im    <= ld_word[15:0];
                    out_mag   <= ld_mag;
                    out_last  <= 1'b0;
                    idx       <= ld_idx;
                    peak_mag  <= '0;
                    peak_idx  <= '0;
                    state     <= SEND;
                end
                SEND: begin
                    if (handshake) begin
                        if (idx == LAST_BIN) begin
                            out_valid  <= 1'b0;
                            out_last   <= 1'b0;
                            // The last beat still competes for the peak; strict
                            // compare keeps the lower index on a tie.
                            peak_bin   <= (out_mag > peak_mag) ? LAST_BIN : peak_idx;
                            peak_valid <= 1'b1;
                            if (capture) begin
                                idx   <= '0;
                                state <= LOAD;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            if (out_mag > peak_mag) begin
                                peak_mag <= out_mag;
                                peak_idx <= idx;
                            end
                            idx      <= ld_idx;
                            out_re   <= ld_word[31:16];
                            out_im   <= ld_word[15:0];
                            out_mag  <= ld_mag;
                            out_last <= (ld_idx == LAST_BIN);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_bin   = idx;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_fft_bin_streamer.sv
// Self-checking bench for fft_bin_streamer.
// A monitor checks every accepted beat against a reference queue.
// It also checks every peak report and output stability during stalls.
// The main sequence runs directed, table-driven and randomized frames.

module tb_fft_bin_streamer;

    localparam int BW = 69;  // {bin, re, im, mag, last}

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        fft_valid;
    logic [31:0] fft_d [16];
    logic        out_ready;

    logic        out_valid;
    logic [3:0]  out_bin;
    logic [15:0] out_re;
    logic [15:0] out_im;
    logic [31:0] out_mag;
    logic        out_last;
    logic        busy;
    logic        peak_valid;
    logic [3:0]  peak_bin;
    logic [7:0]  drop_cnt;
    logic [1:0]  state_dbg;

    fft_bin_streamer #(.NBINS(16), .CNTW(8)) dut (
        .clk(clk), .rst(rst), .fft_valid(fft_valid),
        .fft_d0(fft_d[0]),   .fft_d1(fft_d[1]),   .fft_d2(fft_d[2]),   .fft_d3(fft_d[3]),
        .fft_d4(fft_d[4]),   .fft_d5(fft_d[5]),   .fft_d6(fft_d[6]),   .fft_d7(fft_d[7]),
        .fft_d8(fft_d[8]),   .fft_d9(fft_d[9]),   .fft_d10(fft_d[10]), .fft_d11(fft_d[11]),
        .fft_d12(fft_d[12]), .fft_d13(fft_d[13]), .fft_d14(fft_d[14]), .fft_d15(fft_d[15]),
        .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
        .out_re(out_re), .out_im(out_im), .out_mag(out_mag), .out_last(out_last),
        .busy(busy), .peak_valid(peak_valid), .peak_bin(peak_bin),
        .drop_cnt(drop_cnt), .state_dbg(state_dbg)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ready_mode = 0;  // 0: always 1, 1: 1,0,0,1 pattern, 2: random, 3: always 0

    logic [BW-1:0] exp_q[$];
    logic [3:0]    exp_peak_q[$];
    int            peak_seen = 0;
    int            beats_got = 0;
    logic [31:0]   mag_by_bin [16];
    int            exp_drop = 0;
    logic [31:0]   frm [16];
    logic          prev_stall = 1'b0;
    logic [BW-1:0] prev_beat = '0;

    typedef struct {
        logic [31:0] fill;
        logic [31:0] d3;
        logic [31:0] d5;
        logic [31:0] d9;
        logic [3:0]  exp_peak;
        logic [31:0] exp_mag3;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input string detail);
        tests++;
        fails++;
        $display("FAIL %s: %s", name, detail);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            2:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    endtask

    // Reference: every bin in order with re^2+im^2; peak is the first index
    // holding the maximum magnitude.
    function automatic void model_frame();
        longint best = -1;
        int     bi = 0;
        for (int k = 0; k < 16; k++) begin
            longint re = longint'($signed(frm[k][31:16]));
            longint im = longint'($signed(frm[k][15:0]));
            longint m  = re * re + im * im;
            exp_q.push_back({4'(k), frm[k][31:16], frm[k][15:0], m[31:0], (k == 15)});
            if (m > best) begin
                best = m;
                bi   = k;
            end
        end
        exp_peak_q.push_back(4'(bi));
    endfunction

    function automatic void rand_frame();
        for (int k = 0; k < 16; k++) begin
            case ($urandom_range(0, 7))
                0:       frm[k] = 32'h8000_8000;
                1:       frm[k] = 32'h7fff_8000;
                default: frm[k] = $urandom;
            endcase
        end
    endfunction

    task automatic send();
        fft_d = frm;
        fft_valid = 1'b1;
        tick();
        fft_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int start = peak_seen;
        for (int i = 0; i < budget && peak_seen == start; i++) tick();
        if (peak_seen == start) flag({name, "_timeout"}, "no peak_valid within cycle budget");
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic [BW-1:0] cur;
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            cur = {out_bin, out_re, out_im, out_mag, out_last};
            if (prev_stall) check("stall_hold", {out_valid, cur}, {1'b1, prev_beat});
            if (out_valid && out_ready) begin
                beats_got++;
                mag_by_bin[out_bin] = out_mag;
                if (exp_q.size() == 0) flag("extra_beat", $sformatf("got beat 0x%0h, want none", cur));
                else check("beat", cur, exp_q.pop_front());
            end
            if (peak_valid) begin
                peak_seen++;
                if (exp_peak_q.size() == 0) flag("extra_peak", $sformatf("got peak_bin %0d, want none", peak_bin));
                else check("peak_bin", peak_bin, exp_peak_q.pop_front());
            end
            prev_stall = out_valid && !out_ready;
            prev_beat  = cur;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int pk;

        vecs[0] = '{32'h0,         32'h8000_8000, 32'h0,         32'h0,         4'd3, 32'h8000_0000};
        vecs[1] = '{32'h0,         32'h0,         32'h0003_0004, 32'h0005_0000, 4'd5, 32'h0};
        vecs[2] = '{32'h0,         32'h0001_ffff, 32'h0,         32'hfffb_0000, 4'd9, 32'd2};
        vecs[3] = '{32'h0002_0002, 32'h0002_fffe, 32'h0002_0002, 32'h0002_0002, 4'd0, 32'd8};
        vecs[4] = '{32'h0,         32'h7fff_7fff, 32'hffff_0000, 32'h0,         4'd3, 32'h7ffe_0002};
        vecs[5] = '{32'hffff_0001, 32'hffff_0001, 32'hffff_0001, 32'h0000_8000, 4'd9, 32'd2};

        rst = 1'b0;
        fft_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) fft_d[k] = '0;

        // Reset state
        #3;
        check("reset_stream", {out_valid, out_bin, out_re, out_im, out_mag, out_last}, '0);
        check("reset_status", {busy, peak_valid, peak_bin, drop_cnt, state_dbg}, '0);
        tick();
        rst = 1'b1;
        tick();
        tick();

        // Single frame, re=k, im=-k, continuous ready
        for (int k = 0; k < 16; k++) frm[k] = {16'(k), 16'(-k)};
        model_frame();
        send();
        check("lat_load", {out_valid, busy}, 2'b01);
        tick();
        check("lat_first", {out_valid, out_bin}, {1'b1, 4'd0});
        wait_done("single", 40);
        check("single_peak", peak_bin, 4'd15);
        check("single_mag15", mag_by_bin[15], 32'd450);
        check("single_idle", busy, 1'b0);

        // Backpressure 1,0,0,1
        ready_mode = 1;
        b0 = beats_got;
        rand_frame();
        model_frame();
        send();
        wait_done("backpressure", 100);
        check("bp_beats", beats_got - b0, 16);
        ready_mode = 0;
        tick();

        // Back-to-back: new frame on the bin-15 handshake edge
        rand_frame();
        model_frame();
        send();
        repeat (16) tick();
        check("b2b_last_visible", {out_valid, out_bin, out_last}, {1'b1, 4'd15, 1'b1});
        rand_frame();
        model_frame();
        send();
        check("b2b_load", {out_valid, busy}, 2'b01);
        tick();
        check("b2b_first", {out_valid, out_bin}, {1'b1, 4'd0});
        wait_done("b2b", 40);
        check("b2b_no_drop", drop_cnt, 8'(exp_drop));

        // Drop: second pulse three cycles after the first
        b0 = beats_got;
        rand_frame();
        model_frame();
        send();
        tick();
        tick();
        rand_frame();
        send();
        exp_drop++;
        wait_done("drop", 40);
        check("drop_one", drop_cnt, 8'd1);
        repeat (5) tick();
        check("drop_beats", beats_got - b0, 16);

        // Table: extremes and ties
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 16; k++) frm[k] = vecs[i].fill;
            frm[3] = vecs[i].d3;
            frm[5] = vecs[i].d5;
            frm[9] = vecs[i].d9;
            model_frame();
            send();
            wait_done($sformatf("vec%0d", i), 40);
            check($sformatf("vec%0d_peak", i), peak_bin, vecs[i].exp_peak);
            check($sformatf("vec%0d_mag3", i), mag_by_bin[3], vecs[i].exp_mag3);
            repeat ($urandom_range(0, 2)) tick();
        end

        // Randomized frames with random ready
        ready_mode = 2;
        for (int f = 0; f < 20; f++) begin
            rand_frame();
            model_frame();
            send();
            wait_done($sformatf("rand%0d", f), 200);
            repeat ($urandom_range(0, 3)) tick();
        end
        ready_mode = 0;
        tick();

        // Saturation: stalled frame, 300 refused pulses with changing data
        ready_mode = 3;
        rand_frame();
        model_frame();
        send();
        fft_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 16; k++) fft_d[k] = $urandom;
            tick();
            if (exp_drop < 255) exp_drop++;
            if (i == 99) check("sat_mid", drop_cnt, 8'(exp_drop));
        end
        fft_valid = 1'b0;
        check("sat_final", drop_cnt, 8'hff);
        ready_mode = 0;
        wait_done("sat", 60);
        check("sat_hold", drop_cnt, 8'hff);

        // Reset during beat 7
        rand_frame();
        model_frame();
        send();
        repeat (8) tick();
        check("rst_mid_beat7", {out_valid, out_bin}, {1'b1, 4'd7});
        rst = 1'b0;
        #1;
        exp_q.delete();
        exp_peak_q.delete();
        exp_drop = 0;
        check("rst_mid_stream", {out_valid, out_bin, out_re, out_im, out_mag, out_last}, '0);
        check("rst_mid_status", {busy, peak_valid, peak_bin, drop_cnt, state_dbg}, '0);
        pk = peak_seen;
        repeat (3) tick();
        check("rst_no_peak", peak_seen, pk);
        rst = 1'b1;
        tick();
        rand_frame();
        model_frame();
        send();
        tick();
        check("post_rst_first", {out_valid, out_bin}, {1'b1, 4'd0});
        wait_done("post_rst", 40);
        check("post_rst_drop", drop_cnt, 8'd0);

        repeat (5) tick();
        check("drained_beats", exp_q.size(), 0);
        check("drained_peaks", exp_peak_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fft_bin_streamer.md
Name: fft_bin_streamer

Overview:
- Sits directly downstream of the FFT stage, in parallel with the frequency analyzer.
- On each fft_valid pulse it captures the 16 parallel 32-bit bin words into a frame buffer.
- It then streams the bins out one per beat over a valid/ready interface, with per-bin magnitude-squared and a per-frame peak-bin report.
- Frames arriving while a previous frame is still streaming are dropped and counted.

Parameters:
- NBINS, 16, bins per frame; fixed to match the FFT, index width 4.
- CNTW, 8, width of the saturating drop counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- fft_valid  in  1  one-cycle pulse; fft_d0..fft_d15 are valid in this cycle.
- fft_d0..fft_d15  in  32 each  bin k word: [31:16] signed real, [15:0] signed imaginary.
- out_valid  out  1  a bin beat is presented.
- out_ready  in  1  consumer accepts the beat when out_valid && out_ready.
- out_bin  out  4  bin index of the current beat.
- out_re  out  16  signed real part.
- out_im  out  16  signed imaginary part.
- out_mag  out  32  unsigned re*re + im*im.
- out_last  out  1  high on the bin-15 beat.
- busy  out  1  high whenever state != IDLE.
- peak_valid  out  1  one-cycle pulse after a frame completes.
- peak_bin  out  4  bin index of the largest out_mag in the completed frame.
- drop_cnt  out  CNTW  frames dropped; saturates at all-ones.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, all outputs 0, frame buffer and idx cleared.
  - Reset mid-frame abandons the frame; no peak_valid is issued for it.
- States: IDLE, LOAD, SEND.
- Frame capture:
  - IDLE with fft_valid=1 at a clock edge: all 16 words latch into the buffer; idx <= 0; go to LOAD.
  - LOAD (one cycle): output registers load bin 0 (out_bin, out_re, out_im, out_mag, out_last=0); out_valid <= 1; running peak reset; go to SEND.
  - Latency: out_valid is high on the second rising edge after the edge that sampled fft_valid.
- SEND handshake:
  - out_valid && !out_ready: all out_* held stable.
  - Handshake with idx<15: idx+1; next bin loaded into the output registers at the same edge, giving one beat per cycle under continuous ready.
- Magnitude: computed from the buffer entry as it is loaded.
  - Full 32-bit unsigned result, no truncation.
  - Maximum 0x80000000, for re=im=-32768.
- Peak tracking: running max over the accepted beats. A strictly greater value replaces the current max, so on a tie the lowest bin index wins.
- Frame end: handshake on the bin-15 beat (out_last=1):
  - out_valid <= 0 and out_last <= 0.
  - peak_bin <= final peak, with bin 15 included in the comparison.
  - peak_valid = 1 for exactly one cycle.
  - If fft_valid=1 in that same cycle, the new frame is captured and the state goes to LOAD (back-to-back, not dropped). Otherwise the state goes to IDLE.
- Drops: fft_valid=1 in LOAD, or in SEND except on the final-handshake cycle, leaves the buffer untouched and increments drop_cnt (saturating).
- out_bin: equals idx, always increments 0 to 15, never wraps within a frame.
- peak_bin: holds its value until the next frame completes.

Test Plan:
- Single frame, out_ready=1, fft_dk = {re=k, im=-k}:
  - out_valid at capture+2 edges; 16 consecutive beats with out_mag = 2k² (bin 15 = 450).
  - out_last on beat 16; then peak_valid pulse with peak_bin=15; busy low afterwards.
- Backpressure: out_ready toggled 1,0,0,1 repeating.
  - Outputs stable while stalled.
  - All 16 beats delivered in order with no duplicates or skips.
- Drop: second fft_valid 3 cycles after the first, with out_ready=1.
  - drop_cnt=1; only the first frame is streamed.
  - 300 such drops saturate drop_cnt at 255.
- Back-to-back: fft_valid coincident with the bin-15 handshake.
  - drop_cnt unchanged; second frame's bin 0 appears after one LOAD cycle.
  - peak_valid pulses for the first frame.
- Extremes and ties:
  - fft_d3 = 0x80008000 gives out_mag 0x80000000 and peak_bin=3.
  - bins 5 and 9 with equal maximum magnitude give peak_bin=5.
- Reset mid-frame: rst low during beat 7.
  - All outputs 0 immediately, no peak_valid, busy=0.
  - A subsequent frame streams normally from bin 0.
